// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and helpers for the CPU clock-enable controller.
//   clkctl_state_t   : controller modes (RUN, STOP, STEP, HALT)
//   CLKCTL_SEL_W     : width of the speed-select input
//   clkctl_clamp_sel : clamps a speed select to the legal shift range
package cpu_clk_ctrl_pkg;

    localparam int CLKCTL_SEL_W = 3;

    typedef enum logic [1:0] {
        CLK_RUN  = 2'd0,
        CLK_STOP = 2'd1,
        CLK_STEP = 2'd2,
        CLK_HALT = 2'd3
    } clkctl_state_t;

    // Shift amount s = min(sel, div_w-1); keeps at least one divider bit
    // in the tick mask so the fastest period is 2 cycles.
    function automatic logic [5:0] clkctl_clamp_sel(
        input logic [CLKCTL_SEL_W-1:0] sel,
        input int                      div_w
    );
        logic [5:0] result;
        if (int'(sel) > div_w - 1) begin
            result = 6'(div_w - 1);
        end else begin
            result = 6'(sel);
        end
        return result;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and a
// registered one-cycle press pulse on the debounced 0->1 transition.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   btn_i      : raw asynchronous button, active-high
//   level_o    : debounced button level
//   press_o    : one-cycle pulse on debounced rising edge
module btn_debounce #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizer and level start high so a button held through
            // reset produces no event until it is released and re-pressed.
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= btn_i;
            r_sync2 <= r_sync1;

            // Level follows only after 2^DEB_W consecutive mismatching samples.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign level_o = r_level;
    assign press_o = r_press;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: selectable-speed divider, run/stop and
// single-step modes from debounced buttons, and a sticky halt state.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   run_btn_i   : raw run/stop toggle button
//   step_btn_i  : raw single-step button
//   div_sel_i   : speed select, period = 2^(DIV_W - min(sel, DIV_W-1))
//   halt_i      : CPU halt request (sticky until reset)
//   clk_en_o    : registered one-cycle CPU clock enable
//   running_o   : controller in RUN
//   halted_o    : controller in HALT
//   blink_o     : status LED, active-high
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W     = 19,
    parameter int DEB_W     = 16,
    parameter bit START_RUN = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run_btn_i,
    input  logic                    step_btn_i,
    input  logic [CLKCTL_SEL_W-1:0] div_sel_i,
    input  logic                    halt_i,
    output logic                    clk_en_o,
    output logic                    running_o,
    output logic                    halted_o,
    output logic                    blink_o
);

    logic             w_run_press;
    logic             w_step_press;
    logic [1:0]       w_unused_levels;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_mask;
    logic [5:0]       w_shift;
    logic             w_tick;
    clkctl_state_t    r_state;
    clkctl_state_t    w_state_nxt;
    logic             r_clk_en;
    logic             w_clk_en_nxt;

    btn_debounce #(.DEB_W(DEB_W)) u_run_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (run_btn_i),
        .level_o (w_unused_levels[0]),
        .press_o (w_run_press)
    );

    btn_debounce #(.DEB_W(DEB_W)) u_step_btn (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (step_btn_i),
        .level_o (w_unused_levels[1]),
        .press_o (w_step_press)
    );

    // Tick when the low (DIV_W - s) counter bits are all zero. Because the
    // mask is applied to a free-running counter, a select change only
    // stretches or shortens the period in flight.
    assign w_shift = clkctl_clamp_sel(div_sel_i, DIV_W);
    assign w_mask  = {DIV_W{1'b1}} >> w_shift;
    assign w_tick  = ((r_cnt & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= START_RUN ? CLK_RUN : CLK_STOP;
            r_clk_en <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_clk_en <= w_clk_en_nxt;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_clk_en_nxt = 1'b0;
        case (r_state)
            CLK_RUN: begin
                // Halt wins over the tick so no enable escapes on the halt cycle.
                if (halt_i) begin
                    w_state_nxt = CLK_HALT;
                end else if (w_run_press) begin
                    w_state_nxt = CLK_STOP;
                end else begin
                    w_clk_en_nxt = w_tick;
                end
            end
            CLK_STOP: begin
                if (halt_i) begin
                    w_state_nxt = CLK_HALT;
                end else if (w_run_press) begin
                    w_state_nxt = CLK_RUN;
                end else if (w_step_press) begin
                    w_state_nxt = CLK_STEP;
                end
            end
            CLK_STEP: begin
                w_clk_en_nxt = 1'b1;
                w_state_nxt  = CLK_STOP;
            end
            CLK_HALT: begin
                w_state_nxt = CLK_HALT;
            end
            default: begin
                w_state_nxt = CLK_STOP;
            end
        endcase
    end

    always_comb begin
        blink_o = 1'b1;
        case (r_state)
            CLK_RUN:  blink_o = r_cnt[DIV_W-1];
            CLK_HALT: blink_o = r_cnt[DIV_W-3];
            default:  blink_o = 1'b1;
        endcase
    end

    assign clk_en_o  = r_clk_en;
    assign running_o = (r_state == CLK_RUN);
    assign halted_o  = (r_state == CLK_HALT);

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl (DIV_W=8, DEB_W=2, START_RUN=1).
// A behavioural model advances once per clock edge from the same inputs
// and every output is compared on the following falling edge.
module tb_cpu_clk_ctrl;

    localparam int DIV_W      = 8;
    localparam int DEB_W      = 2;
    localparam bit START_RUN  = 1'b1;
    localparam int PERIOD_MAX = 1 << DIV_W;
    localparam int DEB_LEN    = 1 << DEB_W;

    logic       clk;
    logic       reset;
    logic       run_btn_i;
    logic       step_btn_i;
    logic [2:0] div_sel_i;
    logic       halt_i;
    logic       clk_en_o;
    logic       running_o;
    logic       halted_o;
    logic       blink_o;

    int checks = 0;
    int errors = 0;

    cpu_clk_ctrl #(
        .DIV_W     (DIV_W),
        .DEB_W     (DEB_W),
        .START_RUN (START_RUN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run_btn_i  (run_btn_i),
        .step_btn_i (step_btn_i),
        .div_sel_i  (div_sel_i),
        .halt_i     (halt_i),
        .clk_en_o   (clk_en_o),
        .running_o  (running_o),
        .halted_o   (halted_o),
        .blink_o    (blink_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_RUN, M_STOP, M_STEP, M_HALT} mode_t;

    mode_t m_mode;
    int    m_cnt;
    bit    m_en;
    bit    m_lvl[2];
    int    m_len[2];
    bit    m_pipe[2][2];     // [button][age]: index 1 is the older sample
    int    m_press_edge[2];  // edge number at which the controller acts on a press
    int    edge_n = 0;

    function automatic void model_edge();
        bit seen_run;
        bit seen_step;
        bit tick;
        bit raw[2];
        int s;
        raw[0] = run_btn_i;
        raw[1] = step_btn_i;
        edge_n++;
        if (reset) begin
            m_mode = START_RUN ? M_RUN : M_STOP;
            m_en   = 1'b0;
            m_cnt  = 0;
            for (int b = 0; b < 2; b++) begin
                m_lvl[b]        = 1'b1;
                m_len[b]        = 0;
                m_pipe[b][0]    = 1'b1;
                m_pipe[b][1]    = 1'b1;
                m_press_edge[b] = -1;
            end
            return;
        end
        seen_run  = (m_press_edge[0] == edge_n);
        seen_step = (m_press_edge[1] == edge_n);
        s    = (int'(div_sel_i) > DIV_W - 1) ? DIV_W - 1 : int'(div_sel_i);
        tick = ((m_cnt % (PERIOD_MAX >> s)) == 0);
        case (m_mode)
            M_RUN: begin
                if (halt_i) begin
                    m_mode = M_HALT;
                    m_en   = 1'b0;
                end else if (seen_run) begin
                    m_mode = M_STOP;
                    m_en   = 1'b0;
                end else begin
                    m_en = tick;
                end
            end
            M_STOP: begin
                m_en = 1'b0;
                if (halt_i)         m_mode = M_HALT;
                else if (seen_run)  m_mode = M_RUN;
                else if (seen_step) m_mode = M_STEP;
            end
            M_STEP: begin
                m_en   = 1'b1;
                m_mode = M_STOP;
            end
            default: m_en = 1'b0;
        endcase
        m_cnt = (m_cnt + 1) % PERIOD_MAX;
        for (int b = 0; b < 2; b++) begin
            bit samp;
            samp         = m_pipe[b][1];
            m_pipe[b][1] = m_pipe[b][0];
            m_pipe[b][0] = raw[b];
            if (samp == m_lvl[b]) begin
                m_len[b] = 0;
            end else begin
                m_len[b]++;
                if (m_len[b] == DEB_LEN) begin
                    m_lvl[b] = samp;
                    m_len[b] = 0;
                    if (samp) m_press_edge[b] = edge_n + 2;
                end
            end
        end
    endfunction

    task automatic compare_outputs();
        int exp_blink;
        case (m_mode)
            M_RUN:   exp_blink = (m_cnt >> (DIV_W - 1)) & 1;
            M_HALT:  exp_blink = (m_cnt >> (DIV_W - 3)) & 1;
            default: exp_blink = 1;
        endcase
        check_eq("clk_en", clk_en_o, m_en);
        check_eq("running", running_o, m_mode == M_RUN);
        check_eq("halted", halted_o, m_mode == M_HALT);
        check_eq("blink", blink_o, exp_blink);
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    // which: 0 = run, 1 = step, 2 = both in the same cycle
    task automatic press_btn(input int which, input int hold, input int gap);
        if (which != 1) run_btn_i = 1'b1;
        if (which != 0) step_btn_i = 1'b1;
        cycles(hold);
        run_btn_i  = 1'b0;
        step_btn_i = 1'b0;
        cycles(gap);
    endtask

    // Waits (bounded) for a pulse, then counts cycles to the next one.
    task automatic measure_period(input string tag, input int exp_p);
        bit found;
        int n;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            cycle();
            if (clk_en_o === 1'b1) found = 1'b1;
        end
        check_eq({tag, "_seen"}, found, 1);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            cycle();
            n++;
            if (clk_en_o === 1'b1) found = 1'b1;
        end
        check_eq(tag, found ? n : 0, exp_p);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        run_btn_i  = 1'b0;
        step_btn_i = 1'b0;
        halt_i     = 1'b0;
        div_sel_i  = 3'd0;
        cycles(3);
        check_eq("reset_running", running_o, 1);
        check_eq("reset_clk_en", clk_en_o, 0);

        reset = 1'b0;
        cycle();
        check_eq("first_en_after_reset", clk_en_o, 1);
        measure_period("period_sel0", 256);
        cycles(300);

        div_sel_i = 3'd3;
        measure_period("period_sel3", 32);
        div_sel_i = 3'd7;
        measure_period("period_sel7", 2);
        div_sel_i = 3'd0;
        cycles(45);
        div_sel_i = 3'd3;
        measure_period("period_switch_0_to_3", 32);

        press_btn(0, 10, 20);
        check_eq("stop_after_run_press", running_o, 0);
        press_btn(0, 3, 20);
        check_eq("glitch_ignored", running_o, 0);
        press_btn(1, 6, 20);
        press_btn(1, 6, 20);
        press_btn(2, 6, 20);
        check_eq("run_wins_over_step", running_o, 1);

        halt_i = 1'b1;
        cycles(4);
        halt_i = 1'b0;
        press_btn(0, 8, 10);
        press_btn(1, 8, 10);
        check_eq("halt_sticky", halted_o, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycles(2);
        check_eq("halt_cleared_by_reset", halted_o, 0);

        run_btn_i = 1'b1;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(20);
        check_eq("held_through_reset_no_event", running_o, 1);
        run_btn_i = 1'b0;
        cycles(6);
        press_btn(0, 8, 10);
        check_eq("repress_after_release", running_o, 0);

        for (int seg = 0; seg < 250; seg++) begin
            int kind;
            kind = $urandom_range(0, 11);
            div_sel_i = 3'($urandom_range(0, 7));
            case (kind)
                0, 1, 2: press_btn(0, $urandom_range(1, 9), $urandom_range(0, 15));
                3, 4, 5: press_btn(1, $urandom_range(1, 9), $urandom_range(0, 15));
                6:       press_btn(2, $urandom_range(1, 9), $urandom_range(0, 15));
                7: begin
                    halt_i = 1'b1;
                    cycles($urandom_range(1, 3));
                    halt_i = 1'b0;
                    cycles($urandom_range(0, 10));
                end
                8, 9: begin
                    reset      = 1'b1;
                    run_btn_i  = 1'($urandom_range(0, 1));
                    step_btn_i = 1'($urandom_range(0, 1));
                    cycles($urandom_range(1, 3));
                    reset = 1'b0;
                    cycles($urandom_range(0, 10));
                    run_btn_i  = 1'b0;
                    step_btn_i = 1'b0;
                end
                default: cycles($urandom_range(1, 60));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
